// File: rtl/i2c_apb_master.sv
// APB requester: turns valid/ready commands into single APB SETUP/ACCESS transfers
// and returns write status or read data on a one-cycle response strobe.
module i2c_apb_master #(
    parameter int unsigned RDATA_LAT   = 1,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic       pclk_i,
    input  logic       preset_n_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_write_i,
    input  logic [7:0] cmd_addr_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_error_o,
    output logic       psel_o,
    output logic       penable_o,
    output logic       pwrite_o,
    output logic [7:0] paddr_o,
    output logic [7:0] pwdata_o,
    input  logic [7:0] prdata_i,
    input  logic       pready_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        RDWAIT = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             psel_d, penable_d, pwrite_d, rsp_valid_d, rsp_error_d;
    logic [7:0]       paddr_d, pwdata_d, rsp_rdata_d;
    logic             timeout_hit;

    assign cmd_ready_o = (state_q == IDLE);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_MAX);

    // State, counter and all APB/response outputs are registered here.
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel_o      <= psel_d;
            penable_o   <= penable_d;
            pwrite_o    <= pwrite_d;
            paddr_o     <= paddr_d;
            pwdata_o    <= pwdata_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_rdata_o <= rsp_rdata_d;
            rsp_error_o <= rsp_error_d;
        end
    end

    // Next-state and next-output values; psel/penable describe the state being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        pwrite_d    = pwrite_o;
        paddr_d     = paddr_o;
        pwdata_d    = pwdata_o;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_o;
        rsp_error_d = rsp_error_o;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = cmd_write_i;
                    paddr_d  = cmd_addr_i;
                    pwdata_d = cmd_wdata_i;
                    cnt_d    = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // Completion is checked first so a late pready beats the timeout.
                if (pready_i) begin
                    if (!pwrite_o && (RDATA_LAT != 0)) begin
                        state_d = RDWAIT;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b0;
                        rsp_rdata_d = pwrite_o ? 8'h00 : prdata_i;
                    end
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = 8'h00;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                end
            end
            RDWAIT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_error_d = 1'b0;
                rsp_rdata_d = prdata_i;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
